// File: rtl/gcd_arb_pkg.sv
// gcd_arb_pkg: shared types and helpers for the gcd arbiter.
package gcd_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam int DEF_WIDTH = 16;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gcd_rr_pick.sv
// gcd_rr_pick: combinational round-robin picker, searching from last+1 cyclically.
module gcd_rr_pick import gcd_arb_pkg::*; #(
   parameter int N_REQ = 4,
   localparam int IW = idx_w(N_REQ)
)(
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    last,
   output logic [IW-1:0]    idx,
   output logic             any
);

   // Walk from the farthest candidate back to last+1 so the nearest set bit wins.
   always_comb begin
      idx = '0;
      any = |req;
      for (int k = N_REQ; k >= 1; k--)
         if (req[(int'(last) + k) % N_REQ]) idx = IW'((int'(last) + k) % N_REQ);
   end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin sharing of one gcd unit among N_REQ requesters,
// with a watchdog that turns a hung gcd into an error response.
module gcd_arbiter import gcd_arb_pkg::*; #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int TIMEOUT = 131072
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       ack,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]       result,
   output logic                   err,
   output logic                   busy,
   output logic                   gcd_start,
   output logic [WIDTH-1:0]       gcd_a,
   output logic [WIDTH-1:0]       gcd_b,
   input  logic [WIDTH-1:0]       gcd_answer,
   input  logic                   gcd_done
);

   localparam int IW = idx_w(N_REQ);
   localparam int WW = $clog2(TIMEOUT);

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d, last_q, last_d, pick;
   logic [WW-1:0]    wdog_q, wdog_d;
   logic [N_REQ-1:0] ack_q, ack_d, rsp_q, rsp_d;
   logic [WIDTH-1:0] result_q, result_d, a_q, a_d, b_q, b_d;
   logic             err_q, err_d, start_q, start_d, busy_q, any;

   gcd_rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req  (req),
      .last (last_q),
      .idx  (pick),
      .any  (any)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      last_d   = last_q;
      wdog_d   = wdog_q;
      ack_d    = '0;
      rsp_d    = '0;
      result_d = result_q;
      err_d    = err_q;
      start_d  = 1'b0;
      a_d      = a_q;
      b_d      = b_q;
      unique case (state_q)
         IDLE: if (any) begin
            idx_d      = pick;
            a_d        = req_a[int'(pick)*WIDTH +: WIDTH];
            b_d        = req_b[int'(pick)*WIDTH +: WIDTH];
            ack_d[pick] = 1'b1;
            start_d    = 1'b1;
            state_d    = ISSUE;
         end
         ISSUE: begin
            wdog_d  = '0;
            state_d = WAIT;
         end
         // done is only trusted here: the gcd cleared any stale done on the ISSUE edge
         WAIT: if (gcd_done) begin
            result_d     = gcd_answer;
            err_d        = 1'b0;
            rsp_d[idx_q] = 1'b1;
            state_d      = RESP;
         end else if (wdog_q == WW'(TIMEOUT - 1)) begin
            result_d     = '0;
            err_d        = 1'b1;
            rsp_d[idx_q] = 1'b1;
            state_d      = RESP;
         end else begin
            wdog_d = wdog_q + WW'(1);
         end
         RESP: begin
            last_d  = idx_q;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         last_q   <= IW'(N_REQ - 1);
         wdog_q   <= '0;
         ack_q    <= '0;
         rsp_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         start_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         last_q   <= last_d;
         wdog_q   <= wdog_d;
         ack_q    <= ack_d;
         rsp_q    <= rsp_d;
         result_q <= result_d;
         err_q    <= err_d;
         start_q  <= start_d;
         a_q      <= a_d;
         b_q      <= b_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   assign ack       = ack_q;
   assign rsp_valid = rsp_q;
   assign result    = result_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign gcd_start = start_q;
   assign gcd_a     = a_q;
   assign gcd_b     = b_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed scenarios plus random traffic against a transaction-level
// model of grant order, response timing and gcd results, using a stub gcd.
module tb_gcd_arbiter;

   localparam int N = 4, W = 16, TO = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [N-1:0]     req;
   logic [N*W-1:0]   req_a, req_b;
   logic [N-1:0]     ack, rsp_valid;
   logic [W-1:0]     result, gcd_a, gcd_b;
   logic             err, busy, gcd_start;
   logic [W-1:0]     gcd_answer = '0;
   logic             gcd_done = 1'b0;

   int checks = 0, failures = 0, cyc = 0;
   int fix_lat = 3, rnd_lat = 3, cnt = 0;
   logic [W-1:0] pend = '0;

   gcd_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
      .ack(ack), .rsp_valid(rsp_valid), .result(result), .err(err), .busy(busy),
      .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
      .gcd_answer(gcd_answer), .gcd_done(gcd_done)
   );

   always #5 clk = ~clk;

   function automatic int gcd_f(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   function automatic int rr(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Stub gcd: done clears on the start edge, rises after the chosen latency (0 = hang).
   always @(posedge clk) begin
      if (gcd_start) begin
         gcd_done   <= 1'b0;
         gcd_answer <= 16'hDEAD;
         pend       <= W'(gcd_f(int'(gcd_a), int'(gcd_b)));
         cnt        <= (fix_lat >= 0) ? fix_lat : rnd_lat;
         rnd_lat    = $urandom_range(0, 12);
      end else if (cnt == 1) begin
         gcd_done   <= 1'b1;
         gcd_answer <= pend;
         cnt        <= 0;
      end else if (cnt > 1) begin
         cnt <= cnt - 1;
      end
   end

   // Transaction model: when the arbiter is idle it grants round-robin; the response
   // lands latency+2 cycles after ack, or TIMEOUT+1 cycles after ack on a hang.
   bit model_ok = 0;
   int free_cyc = 0, ack_cyc = -1, rsp_cyc = -1, ack_idx = 0, rsp_idx = 0, m_last = N - 1;
   int ea = 0, eb = 0, eres = 0;
   bit eerr = 0;

   always @(posedge clk) begin
      int c, l, i;
      c = cyc;
      if (!reset_n) begin
         model_ok = 1;
         free_cyc = c + 1;
         m_last   = N - 1;
         ack_cyc  = -1;
         rsp_cyc  = -1;
      end else if (c == free_cyc) begin
         if (req == '0) free_cyc = c + 1;
         else begin
            i       = rr(req, m_last);
            l       = (fix_lat >= 0) ? fix_lat : rnd_lat;
            ack_cyc = c + 1;
            ack_idx = i;
            ea      = int'(req_a[i*W +: W]);
            eb      = int'(req_b[i*W +: W]);
            rsp_idx = i;
            rsp_cyc = (l == 0) ? c + 2 + TO : c + 3 + l;
            eres    = (l == 0) ? 0 : gcd_f(ea, eb);
            eerr    = (l == 0);
            free_cyc = rsp_cyc + 1;
            m_last  = i;
         end
      end
      cyc = c + 1;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("m_ack", ack, (cyc == ack_cyc) ? (1 << ack_idx) : 0);
         chk("m_start", gcd_start, cyc == ack_cyc);
         if (cyc == ack_cyc) begin
            chk("m_gcd_a", gcd_a, ea);
            chk("m_gcd_b", gcd_b, eb);
         end
         chk("m_rsp_valid", rsp_valid, (cyc == rsp_cyc) ? (1 << rsp_idx) : 0);
         if (cyc == rsp_cyc) begin
            chk("m_result", result, eres);
            chk("m_err", err, eerr);
         end
         chk("m_busy", busy, cyc != free_cyc);
      end
   end

   task automatic wait_ack(input logic [N-1:0] exp, output int at);
      int n = 0;
      do begin @(negedge clk); n++; end while (ack == '0 && n < 200);
      chk("d_ack", ack, exp);
      at = cyc;
   endtask

   task automatic wait_rsp(input logic [N-1:0] exp, input logic [W-1:0] r, input logic e, output int at);
      int n = 0;
      do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 200);
      chk("d_rsp_valid", rsp_valid, exp);
      chk("d_result", result, r);
      chk("d_err", err, e);
      at = cyc;
   endtask

   task automatic set_req(input int i, input int a, input int b);
      req[i] = 1'b1;
      req_a[i*W +: W] = W'(a);
      req_b[i*W +: W] = W'(b);
   endtask

   task automatic pulse_reset();
      @(negedge clk) reset_n = 1'b0;
      @(negedge clk) reset_n = 1'b1;
   endtask

   initial begin
      int ta, tr;
      bit bad;
      logic [W-1:0] fair_res [4];
      fair_res = '{16'd4, 16'd8, 16'd4, 16'd8};
      reset_n = 1'b0;
      req = '0;
      req_a = '0;
      req_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_rsp", rsp_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", gcd_start, 0);
      chk("rst_gcd_a", gcd_a, 0);
      chk("rst_gcd_b", gcd_b, 0);
      reset_n = 1'b1;

      @(negedge clk) set_req(0, 21, 15);
      wait_ack(4'b0001, ta);
      req[0] = 1'b0;
      chk("t1_start", gcd_start, 1);
      chk("t1_gcd_a", gcd_a, 21);
      chk("t1_gcd_b", gcd_b, 15);
      wait_rsp(4'b0001, 16'd3, 1'b0, tr);
      chk("t1_latency", tr - ta, 5);
      @(negedge clk) chk("t1_idle", busy, 0);

      pulse_reset();
      set_req(0, 48, 18);
      set_req(2, 35, 14);
      wait_ack(4'b0001, ta);
      req[0] = 1'b0;
      wait_rsp(4'b0001, 16'd6, 1'b0, tr);
      wait_ack(4'b0100, ta);
      req[2] = 1'b0;
      wait_rsp(4'b0100, 16'd7, 1'b0, tr);

      pulse_reset();
      for (int i = 0; i < N; i++) set_req(i, 12 * (i + 1), 8);
      for (int k = 0; k < 6; k++) begin
         wait_ack(4'(1 << (k % 4)), ta);
         wait_rsp(4'(1 << (k % 4)), fair_res[k % 4], 1'b0, tr);
         if (k == 1) chk("t3_spacing", tr - ta, 5);
      end
      req = '0;

      @(negedge clk) fix_lat = 0;
      set_req(1, 9, 6);
      wait_ack(4'b0010, ta);
      req[1] = 1'b0;
      wait_rsp(4'b0010, 16'd0, 1'b1, tr);
      chk("t4_timeout_dist", tr - ta, TO + 1);

      @(negedge clk) fix_lat = 10;
      set_req(3, 8, 4);
      wait_ack(4'b1000, ta);
      req[3] = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      chk("t5_busy", busy, 0);
      bad = 0;
      repeat (15) @(negedge clk) if (rsp_valid != '0) bad = 1;
      chk("t5_no_rsp", bad, 0);
      fix_lat = 2;
      set_req(1, 100, 75);
      wait_ack(4'b0010, ta);
      req[1] = 1'b0;
      wait_rsp(4'b0010, 16'd25, 1'b0, tr);

      @(negedge clk) fix_lat = 8;
      set_req(0, 30, 12);
      wait_ack(4'b0001, ta);
      req[0] = 1'b0;
      set_req(3, 7, 7);
      bad = 0;
      repeat (3) @(negedge clk) if (ack != '0) bad = 1;
      req[3] = 1'b0;
      wait_rsp(4'b0001, 16'd6, 1'b0, tr);
      repeat (10) @(negedge clk) if (ack != '0) bad = 1;
      chk("t6_withdrawn", bad, 0);
      fix_lat = 5;
      set_req(2, 27, 18);
      wait_ack(4'b0100, ta);
      req[2] = 1'b0;
      wait_rsp(4'b0100, 16'd9, 1'b0, tr);

      @(negedge clk) fix_lat = -1;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk);
         reset_n = ($urandom_range(0, 599) != 0);
         for (int i = 0; i < N; i++) begin
            if (req[i] && ack[i]) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            end else if (req[i]) begin
               if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               set_req(i, int'($urandom_range(0, 300)), int'($urandom_range(0, 300)));
            end
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      req = '0;
      repeat (40) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
